lsu_byte_sequencer: RTL
=======================

# lsu_byte_sequencer

Load/store sequencer that sits between the decoded control outputs (`readDataMem`, `WriteDataMem`, `sizeDataMem`, funct3 unsigned bit) and an 8-bit-wide byte-addressed data memory. It accepts one 8/16/32-bit load or store request and serialises it into one memory byte per cycle, little-endian. It returns sign- or zero-extended load data, or a completion for stores, over a valid/ready response port. Misaligned and illegal-size requests complete with an error and make no memory access.

## Interface
- `ADDR_W`, 8: memory byte-address width; request address bits above `ADDR_W` are ignored.
- `DATA_W`, 32: request/response data width; fixed at 32.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  load zero-extend (funct3[2]).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low 1/2/4 bytes are used.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  response accepted.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal size.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_re`  out  1  byte read strobe.
- `mem_we`  out  1  byte write strobe.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte, valid the cycle after the `mem_re` cycle (synchronous read).

## Operation
- States: IDLE, XFER, DRAIN, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request and check it.
  - Error case: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - On error: → RESP with `rsp_err`=1 and `rsp_rdata`=0. No memory strobe is ever asserted.
  - Otherwise: N = 1/2/4, byte counter k = 0, → XFER.
- XFER: one strobe per cycle.
  - `mem_addr` = (addr + k) mod 2^ADDR_W.
  - Store: `mem_we`=1, `mem_wdata`=wdata[8k+7:8k].
  - Load: `mem_re`=1.
  - After k = N−1: store → RESP; load → DRAIN.
- Load capture: `mem_rdata` is stored into byte lane k−1 on each cycle after a read strobe, including the DRAIN cycle.
- DRAIN: no strobes; captures the last byte; → RESP.
- RESP: `rsp_valid`=1.
  - `rsp_rdata` = assembled bytes, extended as follows:
    - byte: sign-extend from bit 7 unless `req_unsigned`;
    - half: sign-extend from bit 15 unless `req_unsigned`;
    - word: unchanged.
  - `rsp_ready`=1 → IDLE.
  - Outputs stay stable while `rsp_ready`=0.
- Stores ignore `req_unsigned`. Loads ignore `req_wdata`.
- Address wrap: the counter wraps modulo 2^ADDR_W. Aligned requests never cross a wrap, but the arithmetic is still defined as stated.

## Timing
- Cycle 0 is the cycle where `req_valid`&&`req_ready` is sampled.
- Byte k is strobed in cycle k+1.
- `rsp_valid` rises in:
  - store: cycle N+1 (byte 2, half 3, word 5);
  - load: cycle N+2 (byte 3, half 4, word 6);
  - error: cycle 1.
- Turnaround: the response handshake in cycle t puts `req_ready`=1 in cycle t+1. There is no request acceptance in the same cycle as the response handshake.
- Reset values: state IDLE; `req_ready`=1. All other outputs are 0: `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_re`, `mem_we`, `mem_addr`, `mem_wdata`. Internal latches are also 0.
- Reset mid-operation:
  - Aborts on the next edge and no further strobes are issued.
  - Bytes already written stay written; there is no rollback.
  - A pending response is dropped.
- `req_*` inputs are sampled only at acceptance; changes afterwards have no effect.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`/`SZ_BAD`, shared with the controller's `sizeDataMem`;
  - state enum `lsu_state_t`;
  - function `lsu_nbytes(size)`.
- Sub-module `lsu_load_extend`: combinational. Inputs: 32-bit assembled data, size, unsigned. Output: the extended word. It is reusable by a future wide-memory path.
- The FSM, byte counter and data latches stay in `lsu_byte_sequencer`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → bytes 0x10..0x13 = EF, BE, AD, DE; store `rsp_valid` at cycle 5; load `rsp_rdata`=0xDEADBEEF at cycle 6, `rsp_err`=0.
- Byte load @0x13 (holding 0xDE): signed → 0xFFFFFFDE; `req_unsigned`=1 → 0x000000DE. Half load @0x12 signed → 0xFFFFDEAD.
- Half load @0x11 and size 11 @0x00 → `rsp_err`=1 and `rsp_rdata`=0 at cycle 1; `mem_re`/`mem_we` never asserted.
- Hold `rsp_ready`=0 for 3 cycles after a word load with `req_valid` held high → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout. The next request is accepted only in the cycle after the handshake.
- Word store 0x11223344 @0x20 with `rst_n`=0 sampled in cycle 2 → 0x20=0x44 and 0x21=0x33 are written, 0x22/0x23 unchanged. All outputs are at reset values the next cycle and `req_ready`=1.
- Byte store 0x5A @0xFF, then byte load @0xFF → `mem_addr`=0xFF, load returns 0x0000005A. Upper address bits (0x1FF) are ignored, giving the same result.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, state type and request helpers for the byte-serial load/store sequencer.
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              uns;
        logic [WORD_W-1:0] wdata;
    } lsu_req_t;

    function automatic logic [2:0] lsu_nbytes(input logic [1:0] size);
        case (size)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Illegal size or natural-alignment violation.
    function automatic logic lsu_req_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled little-endian load word by access size.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [WORD_W-1:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        case (size_i)
            SZ_BYTE: ext_o = {{24{data_i[7]  & ~unsigned_i}}, data_i[7:0]};
            SZ_HALF: ext_o = {{16{data_i[15] & ~unsigned_i}}, data_i[15:0]};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Serialises one 8/16/32-bit load or store into little-endian byte accesses on a byte-wide memory.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    lsu_state_t        state_q;
    lsu_req_t          req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        k_q;
    logic [WORD_W-1:0] data_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    logic [1:0]        last_k_c;
    logic [1:0]        k_next_c;
    logic [1:0]        k_prev_c;
    logic [WORD_W-1:0] asm_c;
    logic [WORD_W-1:0] ext_c;
    logic              unused_addr_c;

    assign unused_addr_c = ^req_addr[31:ADDR_W];

    assign last_k_c = 2'(lsu_nbytes(req_q.size) - 3'd1);
    assign k_next_c = k_q + 2'd1;
    assign k_prev_c = k_q - 2'd1;

    // The final load byte arrives during DRAIN and is merged on the fly.
    always_comb begin
        asm_c = data_q;
        asm_c[{last_k_c, 3'b000} +: 8] = mem_rdata;
    end

    lsu_load_extend u_ext (
        .data_i     (asm_c),
        .size_i     (req_q.size),
        .unsigned_i (req_q.uns),
        .ext_o      (ext_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            k_q         <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q  <= '{write: req_write, size: req_size, uns: req_unsigned,
                                    wdata: WORD_W'(req_wdata)};
                        addr_q <= req_addr[ADDR_W-1:0];
                        k_q    <= '0;
                        data_q <= '0;
                        if (lsu_req_err(req_size, req_addr[1:0])) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_XFER;
                            mem_addr_q  <= req_addr[ADDR_W-1:0];
                            mem_we_q    <= req_write;
                            mem_re_q    <= ~req_write;
                            mem_wdata_q <= req_write ? req_wdata[7:0] : 8'h00;
                        end
                    end
                end
                ST_XFER: begin
                    // Synchronous read: byte k-1 is on mem_rdata while byte k is strobed.
                    if (!req_q.write && k_q != 2'd0) begin
                        data_q[{k_prev_c, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (k_q == last_k_c) begin
                        mem_addr_q  <= '0;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        if (req_q.write) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        k_q        <= k_next_c;
                        mem_addr_q <= addr_q + ADDR_W'(k_next_c);
                        if (req_q.write) begin
                            mem_wdata_q <= req_q.wdata[{k_next_c, 3'b000} +: 8];
                        end
                    end
                end
                ST_DRAIN: begin
                    data_q      <= asm_c;
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= ext_c;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = DATA_W'(rsp_rdata_q);
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule
